// File: rtl/apb_fabric_pkg.sv
// Shared types and constants for the N-target APB3 fabric.
package apb_fabric_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int MAX_TGT    = 16;
  localparam int IDX_W      = $clog2(MAX_TGT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DECERR = 2'd2
  } fabric_state_e;
endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address map: per-region hit vector, lowest-index priority pick
// and miss flag.
module apb_addr_decode
  import apb_fabric_pkg::*;
#(
  parameter int                            N_TGT    = 4,
  parameter logic [N_TGT*APB_ADDR_W-1:0]   TGT_BASE = {N_TGT{32'h0}},
  parameter logic [N_TGT*APB_ADDR_W-1:0]   TGT_MASK = {N_TGT{32'h0}}
) (
  input  logic [APB_ADDR_W-1:0] i_paddr,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_miss
);

  logic [N_TGT-1:0] w_hit;

  for (genvar g = 0; g < N_TGT; g++) begin : g_hit
    assign w_hit[g] = ((i_paddr & ~TGT_MASK[APB_ADDR_W*g +: APB_ADDR_W])
                       == TGT_BASE[APB_ADDR_W*g +: APB_ADDR_W]);
  end

  // Scan from the top down so the lowest hitting index is the last one written.
  always_comb begin
    o_idx = {IDX_W{1'b0}};
    for (int i = N_TGT - 1; i >= 0; i--) begin
      o_idx = w_hit[i] ? IDX_W'(i) : o_idx;
    end
  end

  assign o_miss = ~|w_hit;

endmodule

// File: rtl/apb_fabric_n.sv
// N-target APB3 interconnect with parametrised address map, decode-error
// response and per-transfer timeout watchdog.
module apb_fabric_n
  import apb_fabric_pkg::*;
#(
  parameter int                            N_TGT    = 4,
  parameter logic [N_TGT*APB_ADDR_W-1:0]   TGT_BASE = {N_TGT{32'h0}},
  parameter logic [N_TGT*APB_ADDR_W-1:0]   TGT_MASK = {N_TGT{32'h0}},
  parameter int                            TIMEOUT  = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_psel,
  input  logic                          i_penable,
  input  logic [APB_ADDR_W-1:0]         i_paddr,
  input  logic                          i_pwrite,
  input  logic [APB_DATA_W-1:0]         i_pwdata,
  input  logic [3:0]                    i_pwstrb,
  output logic                          i_pready,
  output logic [APB_DATA_W-1:0]         i_prdata,
  output logic                          i_pslverr,
  output logic [N_TGT-1:0]              t_psel,
  output logic                          t_penable,
  output logic [APB_ADDR_W-1:0]         t_paddr,
  output logic                          t_pwrite,
  output logic [APB_DATA_W-1:0]         t_pwdata,
  output logic [3:0]                    t_pwstrb,
  input  logic [N_TGT-1:0]              t_pready,
  input  logic [N_TGT*APB_DATA_W-1:0]   t_prdata,
  input  logic [N_TGT-1:0]              t_pslverr,
  output logic                          tout_flag,
  output logic [IDX_W-1:0]              tout_idx,
  input  logic                          tout_clr
);

  localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);
  localparam bit              WDOG_EN = (TIMEOUT != 0);

  fabric_state_e          r_state;
  logic [IDX_W-1:0]       r_sel;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_tout_flag;
  logic [IDX_W-1:0]       r_tout_idx;

  logic [IDX_W-1:0]       w_dec_idx;
  logic                   w_dec_miss;
  logic                   w_setup;
  logic [IDX_W-1:0]       w_cur;
  logic [N_TGT-1:0]       w_onehot;
  logic                   w_rdy;
  logic                   w_err;
  logic [APB_DATA_W-1:0]  w_rdata;
  logic [APB_ADDR_W-1:0]  w_mask;
  logic                   w_abort;

  apb_addr_decode #(
    .N_TGT    (N_TGT),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_decode (
    .i_paddr (i_paddr),
    .o_idx   (w_dec_idx),
    .o_miss  (w_dec_miss)
  );

  assign w_setup = i_psel & ~i_penable;
  // The live decode steers the SETUP cycle; the latched index owns ACCESS.
  assign w_cur   = (r_state == ST_ACCESS) ? r_sel : w_dec_idx;

  // Per-target slice select for the current index.
  always_comb begin
    w_onehot = {N_TGT{1'b0}};
    w_rdy    = 1'b0;
    w_err    = 1'b0;
    w_rdata  = {APB_DATA_W{1'b0}};
    w_mask   = {APB_ADDR_W{1'b0}};
    for (int i = 0; i < N_TGT; i++) begin
      if (w_cur == IDX_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_rdy       = t_pready[i];
        w_err       = t_pslverr[i];
        w_rdata     = t_prdata[APB_DATA_W*i +: APB_DATA_W];
        w_mask      = TGT_MASK[APB_ADDR_W*i +: APB_ADDR_W];
      end else begin
        w_onehot[i] = 1'b0;
      end
    end
  end

  // A ready target in the limit cycle still completes normally.
  assign w_abort = WDOG_EN && (r_state == ST_ACCESS) && i_psel &&
                   (r_cnt == CNT_LIM) && !w_rdy;

  assign t_paddr  = i_paddr & w_mask;
  assign t_pwrite = i_pwrite;
  assign t_pwdata = i_pwdata;
  assign t_pwstrb = i_pwstrb;

  // Target selects and initiator response per state.
  always_comb begin
    i_pready  = 1'b0;
    i_prdata  = {APB_DATA_W{1'b0}};
    i_pslverr = 1'b0;
    t_psel    = {N_TGT{1'b0}};
    t_penable = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_setup && !w_dec_miss) begin
          t_psel = w_onehot;
        end else begin
          t_psel = {N_TGT{1'b0}};
        end
      end
      ST_ACCESS: begin
        if (!i_psel) begin
          t_psel = {N_TGT{1'b0}};
        end else if (w_abort) begin
          i_pready  = 1'b1;
          i_pslverr = 1'b1;
        end else begin
          t_psel    = w_onehot;
          t_penable = i_penable;
          i_pready  = w_rdy;
          i_prdata  = w_rdy ? w_rdata : {APB_DATA_W{1'b0}};
          i_pslverr = w_rdy & w_err;
        end
      end
      ST_DECERR: begin
        i_pready  = 1'b1;
        i_pslverr = 1'b1;
      end
      default: begin
        t_psel = {N_TGT{1'b0}};
      end
    endcase
  end

  // Transfer FSM with saturating wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= {IDX_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= {CNT_W{1'b0}};
          if (w_setup && w_dec_miss) begin
            r_state <= ST_DECERR;
          end else if (w_setup) begin
            r_state <= ST_ACCESS;
            r_sel   <= w_dec_idx;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (!i_psel || w_rdy || w_abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
          end else if (r_cnt != CNT_LIM) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= r_cnt;
          end
        end
        ST_DECERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Sticky timeout record; a new abort beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tout_flag <= 1'b0;
      r_tout_idx  <= {IDX_W{1'b0}};
    end else if (w_abort) begin
      r_tout_flag <= 1'b1;
      if (!r_tout_flag) begin
        r_tout_idx <= r_sel;
      end
    end else if (tout_clr) begin
      r_tout_flag <= 1'b0;
      r_tout_idx  <= {IDX_W{1'b0}};
    end
  end

  assign tout_flag = r_tout_flag;
  assign tout_idx  = r_tout_idx;

endmodule

// File: tb/tb_apb_fabric_n.sv
// Randomized bench for apb_fabric_n: two fabrics (RAM/UART map with watchdog,
// overlapping map without) checked against an address-map/transfer model.
module tb_apb_fabric_n;

  localparam logic [63:0] A_BASE = {32'h8000_0000, 32'h0000_0000};
  localparam logic [63:0] A_MASK = {32'h0000_0FFF, 32'h7FFF_FFFF};
  localparam logic [63:0] B_BASE = {32'h0000_0000, 32'h0000_0000};
  localparam logic [63:0] B_MASK = {32'h0000_FFFF, 32'h0000_00FF};
  localparam int          A_TO   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  psel;
  logic        penable, pwrite, tclr;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pwstrb;
  logic [1:0]  tready, terr;
  logic [63:0] trdata;

  logic        a_pready, a_pslverr, a_tpen, a_tpwrite, a_flag;
  logic [31:0] a_prdata, a_tpaddr, a_tpwdata;
  logic [1:0]  a_tpsel;
  logic [3:0]  a_tpwstrb, a_idx;
  logic        b_pready, b_pslverr, b_tpen, b_tpwrite, b_flag;
  logic [31:0] b_prdata, b_tpaddr, b_tpwdata;
  logic [1:0]  b_tpsel;
  logic [3:0]  b_tpwstrb, b_idx;

  logic        v_pready, v_pslverr, v_tpen, v_tpwrite, v_flag;
  logic [31:0] v_prdata, v_tpaddr, v_tpwdata;
  logic [1:0]  v_tpsel;
  logic [3:0]  v_tpwstrb, v_idx;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   cur      = 0;
  bit   mflag [2];
  logic [3:0] midx [2];

  always #5 clk = ~clk;

  apb_fabric_n #(.N_TGT(2), .TGT_BASE(A_BASE), .TGT_MASK(A_MASK), .TIMEOUT(A_TO)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_psel(psel[0]), .i_penable(penable), .i_paddr(paddr),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pwstrb(pwstrb), .i_pready(a_pready),
    .i_prdata(a_prdata), .i_pslverr(a_pslverr), .t_psel(a_tpsel), .t_penable(a_tpen),
    .t_paddr(a_tpaddr), .t_pwrite(a_tpwrite), .t_pwdata(a_tpwdata), .t_pwstrb(a_tpwstrb),
    .t_pready(tready), .t_prdata(trdata), .t_pslverr(terr), .tout_flag(a_flag),
    .tout_idx(a_idx), .tout_clr(tclr));

  apb_fabric_n #(.N_TGT(2), .TGT_BASE(B_BASE), .TGT_MASK(B_MASK), .TIMEOUT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_psel(psel[1]), .i_penable(penable), .i_paddr(paddr),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pwstrb(pwstrb), .i_pready(b_pready),
    .i_prdata(b_prdata), .i_pslverr(b_pslverr), .t_psel(b_tpsel), .t_penable(b_tpen),
    .t_paddr(b_tpaddr), .t_pwrite(b_tpwrite), .t_pwdata(b_tpwdata), .t_pwstrb(b_tpwstrb),
    .t_pready(tready), .t_prdata(trdata), .t_pslverr(terr), .tout_flag(b_flag),
    .tout_idx(b_idx), .tout_clr(tclr));

  always_comb begin
    if (cur == 0) begin
      {v_pready, v_pslverr, v_tpen, v_tpwrite, v_flag} = {a_pready, a_pslverr, a_tpen, a_tpwrite, a_flag};
      {v_prdata, v_tpaddr, v_tpwdata, v_tpsel, v_tpwstrb, v_idx} = {a_prdata, a_tpaddr, a_tpwdata, a_tpsel, a_tpwstrb, a_idx};
    end else begin
      {v_pready, v_pslverr, v_tpen, v_tpwrite, v_flag} = {b_pready, b_pslverr, b_tpen, b_tpwrite, b_flag};
      {v_prdata, v_tpaddr, v_tpwdata, v_tpsel, v_tpwstrb, v_idx} = {b_prdata, b_tpaddr, b_tpwdata, b_tpsel, b_tpwstrb, b_idx};
    end
  end

  // Address map rule: region i hits iff (addr & ~mask_i) == base_i; lowest hit wins.
  function automatic int model_dec(input int k, input logic [31:0] a);
    logic [63:0] b, m;
    b = (k == 0) ? A_BASE : B_BASE;
    m = (k == 0) ? A_MASK : B_MASK;
    for (int i = 0; i < 2; i++) begin
      if ((a & ~m[32*i +: 32]) == b[32*i +: 32]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_mask(input int k, input int i);
    logic [63:0] m;
    m = (k == 0) ? A_MASK : B_MASK;
    return m[32*i +: 32];
  endfunction

  // One full transfer: SETUP then ACCESS until the model says it completes.
  task automatic xfer(input int k, input logic [31:0] addr, input int waits,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] e,
                      input bit clr_ab);
    int idx, lim;
    logic [1:0] esel;
    logic [31:0] emask;
    logic [36:0] obs, expv;
    bit done, ab;
    idx   = model_dec(k, addr);
    lim   = (k == 0) ? A_TO : 0;
    esel  = (idx < 0) ? 2'b00 : ((idx == 0) ? 2'b01 : 2'b10);
    emask = (idx < 0) ? 32'h0 : model_mask(k, idx);
    @(posedge clk); #1;
    cur = k; psel = (k == 0) ? 2'b01 : 2'b10; penable = 1'b0; paddr = addr;
    pwrite = 1'($urandom); pwdata = $urandom; pwstrb = 4'($urandom);
    tready = 2'b00; trdata = {d1, d0}; terr = e; tclr = 1'b0;
    @(negedge clk);
    n_checks++;
    obs  = {v_pready, v_pslverr, v_tpsel, v_tpen, v_prdata};
    expv = {1'b0, 1'b0, esel, 1'b0, 32'h0};
    if (obs !== expv) begin
      n_errs++; $display("FAIL setup_resp k=%0d addr=%h got=%h exp=%h", k, addr, obs, expv);
    end
    n_checks++;
    if ({(idx < 0) ? 32'h0 : v_tpaddr, v_tpwdata, v_tpwstrb, v_tpwrite} !== {addr & emask, pwdata, pwstrb, pwrite}) begin
      n_errs++; $display("FAIL setup_passthru k=%0d addr=%h got paddr=%h wdata=%h exp paddr=%h wdata=%h",
                         k, addr, v_tpaddr, v_tpwdata, addr & emask, pwdata);
    end
    n_checks++;
    if ({v_flag, v_idx} !== {mflag[k], midx[k]}) begin
      n_errs++; $display("FAIL setup_tout k=%0d got=%b/%0d exp=%b/%0d", k, v_flag, v_idx, mflag[k], midx[k]);
    end
    done = 1'b0;
    for (int c = 0; !done && c < 100; c++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      tready  = (c >= waits) ? 2'b11 : 2'b00;
      ab      = (idx >= 0) && (lim != 0) && (c == lim) && (waits > lim);
      tclr    = clr_ab && ab;
      if (idx < 0 || ab) begin
        expv = {1'b1, 1'b1, 2'b00, 1'b0, 32'h0}; done = 1'b1;
      end else if (c >= waits) begin
        expv = {1'b1, e[idx], esel, 1'b1, (idx == 1) ? d1 : d0}; done = 1'b1;
      end else begin
        expv = {1'b0, 1'b0, esel, 1'b1, 32'h0};
      end
      @(negedge clk);
      n_checks++;
      obs = {v_pready, v_pslverr, v_tpsel, v_tpen, v_prdata};
      if (obs !== expv) begin
        n_errs++; $display("FAIL access_resp k=%0d addr=%h cyc=%0d got=%h exp=%h", k, addr, c, obs, expv);
      end
      n_checks++;
      if ((idx >= 0 && !ab) ? (v_tpaddr !== (addr & emask)) : 1'b0) begin
        n_errs++; $display("FAIL access_paddr k=%0d got=%h exp=%h", k, v_tpaddr, addr & emask);
      end
      n_checks++;
      if ({v_flag, v_idx} !== {mflag[k], midx[k]}) begin
        n_errs++; $display("FAIL access_tout k=%0d got=%b/%0d exp=%b/%0d", k, v_flag, v_idx, mflag[k], midx[k]);
      end
      if (ab) begin
        if (!mflag[k]) midx[k] = 4'(idx);
        mflag[k] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input bit clr);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      psel = 2'b00; penable = 1'b0; tready = 2'b00; tclr = clr;
      @(negedge clk);
      n_checks++;
      if ({v_pready, v_pslverr, v_tpsel, v_tpen, v_prdata} !== 37'h0) begin
        n_errs++; $display("FAIL idle_resp k=%0d got=%h exp=0", cur, {v_pready, v_pslverr, v_tpsel, v_tpen, v_prdata});
      end
      n_checks++;
      if ({v_flag, v_idx} !== {mflag[cur], midx[cur]}) begin
        n_errs++; $display("FAIL idle_tout k=%0d got=%b/%0d exp=%b/%0d", cur, v_flag, v_idx, mflag[cur], midx[cur]);
      end
      if (clr) begin
        mflag[0] = 1'b0; mflag[1] = 1'b0; midx[0] = 4'd0; midx[1] = 4'd0;
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      cur = k; #1;
      n_checks++;
      if ({v_pready, v_pslverr, v_tpsel, v_tpen, v_prdata, v_flag, v_idx} !== 42'h0) begin
        n_errs++; $display("FAIL reset_state k=%0d got=%h exp=0", k, {v_pready, v_pslverr, v_tpsel, v_tpen, v_prdata, v_flag, v_idx});
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    cur = 0;
  endtask

  task automatic test_spec_vectors();
    xfer(0, 32'h8000_0004, 0, $urandom, $urandom, 2'b00, 1'b0);
    xfer(0, 32'h0000_0100, 3, 32'hDEAD_BEEF, $urandom, 2'b10, 1'b0);
    xfer(0, 32'h9000_0000, 0, $urandom, $urandom, 2'b00, 1'b0);
    xfer(0, 32'h8000_0010, 20, $urandom, $urandom, 2'b00, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
  endtask

  task automatic test_overlap();
    xfer(1, 32'h0000_0010, 1, $urandom, $urandom, 2'b01, 1'b0);
    xfer(1, 32'h0000_1234, 2, $urandom, $urandom, 2'b10, 1'b0);
    xfer(1, 32'h0002_0000, 0, $urandom, $urandom, 2'b00, 1'b0);
    xfer(1, 32'h0000_0055, 12, $urandom, $urandom, 2'b00, 1'b0);
    idle(1, 1'b0);
  endtask

  task automatic test_clr_vs_set();
    xfer(0, 32'h8000_0000, 15, $urandom, $urandom, 2'b00, 1'b1);
    xfer(0, 32'h0000_0200, 12, $urandom, $urandom, 2'b00, 1'b1);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
  endtask

  task automatic test_drop();
    @(posedge clk); #1;
    cur = 0; psel = 2'b01; penable = 1'b0; paddr = 32'h0000_0040; tready = 2'b00; tclr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1 penable = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({v_pready, v_tpsel} !== 3'b001) begin
        n_errs++; $display("FAIL drop_wait cyc=%0d got=%b exp=001", c, {v_pready, v_tpsel});
      end
    end
    @(posedge clk); #1 psel = 2'b00; penable = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({v_pready, v_pslverr, v_tpsel, v_tpen, v_prdata} !== 37'h0) begin
      n_errs++; $display("FAIL drop_resp got=%h exp=0", {v_pready, v_pslverr, v_tpsel, v_tpen, v_prdata});
    end
    idle(1, 1'b0);
    xfer(0, 32'h8000_0008, 5, $urandom, $urandom, 2'b00, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 12; n++) begin
      xfer(0, (n % 3 == 0) ? 32'hA000_0000 : (n % 3 == 1) ? 32'h8000_0000 | ($urandom & 32'hFFF) : $urandom & 32'h7FFF_FFFF,
           $urandom_range(0, 3), $urandom, $urandom, 2'($urandom), 1'b0);
    end
  endtask

  task automatic test_random();
    int k, s;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 1);
      s = $urandom_range(0, 2);
      if (k == 0) a = (s == 0) ? ($urandom & 32'h7FFF_FFFF) : (s == 1) ? (32'h8000_0000 | ($urandom & 32'hFFF)) : ($urandom | 32'h8000_1000);
      else        a = (s == 0) ? ($urandom & 32'hFF) : (s == 1) ? (($urandom & 32'hFFFF) | 32'h100) : ($urandom | 32'h1_0000);
      xfer(k, a, $urandom_range(0, 11), $urandom, $urandom, 2'($urandom), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    cur = 0; psel = 2'b01; penable = 1'b0; paddr = 32'h0000_0300; tready = 2'b00; tclr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1 penable = 1'b1;
    end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    mflag[0] = 1'b0; mflag[1] = 1'b0; midx[0] = 4'd0; midx[1] = 4'd0;
    n_checks++;
    if ({v_pready, v_pslverr, v_tpsel, v_tpen, v_prdata, v_flag, v_idx} !== 42'h0) begin
      n_errs++; $display("FAIL reset_mid got=%h exp=0", {v_pready, v_pslverr, v_tpsel, v_tpen, v_prdata, v_flag, v_idx});
    end
    @(posedge clk); #1 rst_n = 1'b1; psel = 2'b00; penable = 1'b0;
    xfer(0, 32'h8000_0004, 2, $urandom, $urandom, 2'b00, 1'b0);
    xfer(0, 32'h0000_0010, 0, $urandom, $urandom, 2'b01, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; psel = 2'b00; penable = 1'b0; paddr = 32'h0; pwrite = 1'b0;
    pwdata = 32'h0; pwstrb = 4'h0; tready = 2'b00; terr = 2'b00; trdata = 64'h0; tclr = 1'b0;
    mflag[0] = 1'b0; mflag[1] = 1'b0; midx[0] = 4'd0; midx[1] = 4'd0;
    #13;
    test_reset();
    test_spec_vectors();
    test_overlap();
    test_clr_vs_set();
    test_drop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    idle(2, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
